// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared widths and state encoding for the program loader
package loader_pkg;

    localparam int LOADER_ADDR_W = 8;
    localparam int LOADER_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        RUN  = 3'd4,
        ERR  = 3'd5
    } loader_state_t;

endpackage

// File: rtl/checksum_accumulator.sv
// rtl/checksum_accumulator.sv - modular byte sum, cleared at session start
module checksum_accumulator
    import loader_pkg::*;
#(
    parameter int W = LOADER_DATA_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] din,
    output logic [W-1:0] sum
);

    // clear wins over enable so a byte arriving with start is dropped
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (enable) begin
            sum <= sum + din;
        end
    end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - streams a length-prefixed, checksummed image into instruction memory
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = LOADER_ADDR_W,
    parameter int DATA_W = LOADER_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_run,
    output logic              busy,
    output logic              error,
    output logic [ADDR_W-1:0] load_count
);

    loader_state_t     state_q;
    loader_state_t     state_d;
    logic [ADDR_W-1:0] len_m1;
    logic [DATA_W-1:0] csum;
    logic              accept;
    logic              last_byte;

    // in_ready depends on state only; start suppresses acceptance instead
    assign in_ready  = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
    assign busy      = in_ready;
    assign cpu_run   = (state_q == RUN);
    assign error     = (state_q == ERR);
    assign accept    = in_valid && in_ready && !start;
    // length is stored minus one so a zero length byte naturally means 256
    assign last_byte = (load_count == len_m1);

    checksum_accumulator #(
        .W(DATA_W)
    ) u_csum (
        .clock  (clock),
        .reset  (reset),
        .clear  (start),
        .enable (accept && (state_q == DATA)),
        .din    (in_data),
        .sum    (csum)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = LEN;
        end else if (accept) begin
            case (state_q)
                LEN:     state_d = DATA;
                DATA:    state_d = last_byte ? CSUM : DATA;
                CSUM:    state_d = (in_data == csum) ? RUN : ERR;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            load_count <= '0;
            len_m1     <= '0;
        end else begin
            imem_we <= 1'b0;
            if (start) begin
                load_count <= '0;
                len_m1     <= '0;
            end else if (accept) begin
                if (state_q == LEN) begin
                    len_m1 <= ADDR_W'(in_data) - ADDR_W'(1);
                end else if (state_q == DATA) begin
                    imem_we    <= 1'b1;
                    imem_addr  <= load_count;
                    imem_wdata <= in_data;
                    load_count <= load_count + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - scoreboard bench for program_loader
module tb_program_loader;

    logic       clock;
    logic       reset;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       imem_we;
    logic [7:0] imem_addr;
    logic [7:0] imem_wdata;
    logic       cpu_run;
    logic       busy;
    logic       error;
    logic [7:0] load_count;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          wr_count = 0;
    int          base;
    logic [15:0] exp_q[$];
    logic [7:0]  stim[$];

    program_loader #(
        .ADDR_W(8),
        .DATA_W(8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_run    (cpu_run),
        .busy       (busy),
        .error      (error),
        .load_count (load_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge clock) begin
        if (imem_we) begin
            logic [15:0] e;
            wr_count++;
            check("sb_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("imem_addr", imem_addr, e[15:8]);
                check("imem_wdata", imem_wdata, e[7:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clock);
            if (in_ready) begin
                tick();
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!done) check("send_accept", 32'(done), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_stream(input int gap);
        int n;
        n = (stim[0] == 8'h00) ? 256 : int'(stim[0]);
        for (int i = 0; i < stim.size(); i++) begin
            if (i >= 1 && i <= n) exp_q.push_back({8'(i - 1), stim[i]});
            send_byte(stim[i]);
            repeat (gap) tick();
        end
        repeat (3) tick();
        check("sb_drained", exp_q.size(), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_imem_we"}, imem_we, 0);
        check({tag, "_imem_addr"}, imem_addr, 0);
        check({tag, "_imem_wdata"}, imem_wdata, 0);
        check({tag, "_cpu_run"}, cpu_run, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_load_count"}, load_count, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) tick();
        check_idle_outputs("reset");
        reset = 1'b0;
        tick();
        check("post_reset_busy", busy, 0);

        // simple good load
        base = wr_count;
        pulse_start();
        check("start_busy", busy, 1);
        stim = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
        run_stream(0);
        check("ok_writes", wr_count - base, 3);
        check("ok_load_count", load_count, 3);
        check("ok_cpu_run", cpu_run, 1);
        check("ok_error", error, 0);
        check("ok_busy", busy, 0);

        // checksum mismatch
        base = wr_count;
        pulse_start();
        check("restart_cpu_run", cpu_run, 0);
        stim = '{8'h02, 8'hAA, 8'hBB, 8'h00};
        run_stream(0);
        check("err_writes", wr_count - base, 2);
        check("err_error", error, 1);
        check("err_cpu_run", cpu_run, 0);
        check("err_in_ready", in_ready, 0);
        repeat (3) tick();
        check("err_sticky", error, 1);

        // full 256-byte image, address wraps
        base = wr_count;
        pulse_start();
        check("start_clears_error", error, 0);
        stim = '{8'h00};
        for (int i = 0; i < 256; i++) stim.push_back(8'(i));
        stim.push_back(8'h80);
        run_stream(0);
        check("full_writes", wr_count - base, 256);
        check("full_load_count", load_count, 0);
        check("full_cpu_run", cpu_run, 1);
        check("full_last_addr", imem_addr, 8'hFF);

        // same as the first load, with a bubble after every byte
        base = wr_count;
        pulse_start();
        stim = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
        run_stream(1);
        check("gap_writes", wr_count - base, 3);
        check("gap_load_count", load_count, 3);
        check("gap_cpu_run", cpu_run, 1);
        check("gap_error", error, 0);

        // stall in DATA, then reset after two of three data bytes
        base = wr_count;
        pulse_start();
        send_byte(8'h03);
        exp_q.push_back({8'h00, 8'h11});
        send_byte(8'h11);
        repeat (5) tick();
        check("stall_busy", busy, 1);
        check("stall_load_count", load_count, 1);
        exp_q.push_back({8'h01, 8'h22});
        send_byte(8'h22);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_idle_outputs("mid_reset");
        in_valid = 1'b1;
        in_data  = 8'h33;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("release_in_ready", in_ready, 0);
        check("release_busy", busy, 0);
        in_valid = 1'b0;
        repeat (2) tick();
        check("reset_writes", wr_count - base, 2);
        check("reset_sb_drained", exp_q.size(), 0);

        // start while running, with a byte offered on the same cycle
        pulse_start();
        stim = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
        run_stream(0);
        check("run_before_restart", cpu_run, 1);
        base     = wr_count;
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        check("restart_run_low", cpu_run, 0);
        check("restart_busy", busy, 1);
        check("restart_load_count", load_count, 0);
        stim = '{8'h02, 8'h01, 8'h02, 8'h03};
        run_stream(0);
        check("restart_writes", wr_count - base, 2);
        check("restart_final_count", load_count, 2);
        check("restart_final_run", cpu_run, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
